// File: rtl/mem_responder.sv
// mem_responder: arbitrates instruction and data fetch requests onto one single-port RAM.
// Latency: a request sampled in IDLE hits two cycles later if the RAM answers in its first access cycle; 3-cycle minimum spacing.
// Backpressure: requesters hold until their hit; the RAM stalls via ram_ready, bounded by TIMEOUT (0 = unbounded).
//
// Ports:
//   clk, nrst                       clock (rising edge), asynchronous active-low reset
//   imem_ren/imem_addr -> ihit/imem_load          instruction read side
//   dmem_ren/dmem_wen/dmem_addr/dmem_store
//                      -> dhit/dmem_load          data read/write side
//   err                             pulses with a hit that timed out or was misaligned
//   ram_ren/ram_wen/ram_addr/ram_wdat, ram_rdat/ram_ready   single-port RAM side
module mem_responder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       TIMEOUT   = 64,
  parameter logic [DATA_W-1:0] FAIL_WORD = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              imem_ren,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              ihit,
  output logic [DATA_W-1:0] imem_load,
  input  logic              dmem_ren,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_store,
  output logic              dhit,
  output logic [DATA_W-1:0] dmem_load,
  output logic              err,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdat,
  input  logic [DATA_W-1:0] ram_rdat,
  input  logic              ram_ready
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_d;
  logic              r_is_d;
  logic              r_wen;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-3:0] r_waddr;
  logic [DATA_W-1:0] r_wdat;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;

  logic w_d_pend;
  logic w_grant;
  logic w_grant_d;
  logic w_timeout;

  assign w_d_pend  = dmem_ren | dmem_wen;
  assign w_grant   = w_d_pend | imem_ren;
  // On contention the side that did not win last time goes first.
  assign w_grant_d = w_d_pend & (~imem_ren | ~r_last_d);
  // Last permitted wait cycle; a ram_ready arriving in this same cycle still wins.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  assign imem_load = r_iload;
  assign dmem_load = r_dload;
  assign ram_addr  = r_waddr;
  assign ram_wdat  = r_wdat;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes and hits decode from the state register only, so a reset
  // drops them without waiting for a clock edge.
  always_comb begin
    w_next  = r_state;
    ram_ren = 1'b0;
    ram_wen = 1'b0;
    ihit    = 1'b0;
    dhit    = 1'b0;
    err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next = w_grant_d ? DACC : IACC;
        end
      end
      IACC: begin
        ram_ren = 1'b1;
        if (ram_ready || w_timeout) begin
          w_next = RESP;
        end
      end
      DACC: begin
        ram_ren = ~r_wen;
        ram_wen = r_wen;
        if (ram_ready || w_timeout) begin
          w_next = RESP;
        end
      end
      RESP: begin
        // Requests are not looked at here, so a request still held after
        // its hit is not accepted a second time.
        ihit   = ~r_is_d;
        dhit   = r_is_d;
        err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_d <= 1'b0;
      r_is_d   <= 1'b0;
      r_wen    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_waddr  <= '0;
      r_wdat   <= '0;
      r_iload  <= '0;
      r_dload  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_grant) begin
            r_last_d <= w_grant_d;
            r_is_d   <= w_grant_d;
            if (w_grant_d) begin
              // ren and wen together resolve to a write.
              r_wen   <= dmem_wen;
              r_wdat  <= dmem_store;
              r_waddr <= dmem_addr[ADDR_W-1:2];
              r_err   <= (dmem_addr[1:0] != 2'b00);
            end else begin
              r_waddr <= imem_addr[ADDR_W-1:2];
              r_err   <= (imem_addr[1:0] != 2'b00);
            end
          end
        end
        IACC, DACC: begin
          r_cnt <= r_cnt + 1'b1;
          if (ram_ready) begin
            if (!r_is_d) begin
              r_iload <= ram_rdat;
            end else if (!r_wen) begin
              r_dload <= ram_rdat;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_is_d) begin
              r_iload <= FAIL_WORD;
            end else if (!r_wen) begin
              r_dload <= FAIL_WORD;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
